// File: rtl/control_pkg.sv
// Shared constants for the control-unit pipeline register: widths, field
// bit positions of the 44-bit microinstruction, and condition-select encodings.
package control_pkg;
  localparam int WORD_W  = 44;
  localparam int STATE_W = 7;

  localparam int IRLD_B   = 43;
  localparam int PCLD_B   = 42;
  localparam int NPCLD_B  = 41;
  localparam int RFLD_B   = 40;
  localparam int MA_B     = 39;
  localparam int MB_LSB   = 37;
  localparam int MC_B     = 36;
  localparam int ME_B     = 35;
  localparam int MF_B     = 34;
  localparam int MPA_B    = 33;
  localparam int MP_B     = 32;
  localparam int MR_B     = 31;
  localparam int RW_B     = 30;
  localparam int MOV_B    = 29;
  localparam int MDRLD_B  = 28;
  localparam int MARLD_B  = 27;
  localparam int OPC_LSB  = 21;
  localparam int CIN_B    = 20;
  localparam int SSE_LSB  = 18;
  localparam int OP_LSB   = 14;
  localparam int CR_LSB   = 7;
  localparam int INV_B    = 6;
  localparam int INCRLD_B = 5;
  localparam int S_LSB    = 3;
  localparam int N_LSB    = 0;

  typedef enum logic [1:0] {
    COND_MOC  = 2'b00,
    COND_COND = 2'b01,
    COND_DMOC = 2'b10,
    COND_ZERO = 2'b11
  } cond_sel_e;
endpackage

// File: rtl/cond_select.sv
// Sequencer condition mux: picks moc/cond/dmoc by S, then applies Inv.
module cond_select
  import control_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic       moc_i,
  input  logic       cond_i,
  input  logic       dmoc_i,
  input  logic       inv_i,
  output logic       raw_o,
  output logic       sts_o
);
  always_comb begin
    raw_o = 1'b0;
    case (cond_sel_e'(sel_i))
      COND_MOC:  raw_o = moc_i;
      COND_COND: raw_o = cond_i;
      COND_DMOC: raw_o = dmoc_i;
      default:   raw_o = 1'b0;
    endcase
  end

  assign sts_o = raw_o ^ inv_i;
endmodule

// File: rtl/control_register.sv
// Microinstruction pipeline register with decoded field outputs, condition
// select and next-address incrementer. CTRL_REG_LOAD_EN adds a ld_en input.
module control_register
  import control_pkg::*;
#(
  parameter int WORD_W  = control_pkg::WORD_W,
  parameter int STATE_W = control_pkg::STATE_W
) (
  input  logic               clk,
  input  logic               reset,
`ifdef CTRL_REG_LOAD_EN
  input  logic               ld_en,
`endif
  input  logic [WORD_W-1:0]  state_signals,
  input  logic [STATE_W-1:0] cur_state,
  input  logic               moc,
  input  logic               cond,
  input  logic               dmoc,
  input  logic [STATE_W-1:0] next_addr,
  output logic               IRld,
  output logic               PCld,
  output logic               nPCld,
  output logic               RFld,
  output logic               MA,
  output logic [1:0]         MB,
  output logic               MC,
  output logic               ME,
  output logic               MF,
  output logic               MPA,
  output logic               MP,
  output logic               MR,
  output logic               RW,
  output logic               MOV,
  output logic               MDRld,
  output logic               MARld,
  output logic [5:0]         OpC,
  output logic               Cin,
  output logic [1:0]         SSE,
  output logic [3:0]         OP,
  output logic [STATE_W-1:0] CR,
  output logic               Inv,
  output logic               IncRld,
  output logic [1:0]         S,
  output logic [2:0]         N,
  output logic [STATE_W-1:0] active_state,
  output logic               cond_raw,
  output logic               sts,
  output logic [STATE_W-1:0] inc_addr
);
  logic [WORD_W-1:0]  word_q, word_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               load;

`ifdef CTRL_REG_LOAD_EN
  assign load = ld_en;
`else
  assign load = 1'b1;
`endif

  always_comb begin
    word_d  = word_q;
    state_d = state_q;
    if (load) begin
      word_d  = state_signals;
      state_d = cur_state;
    end
  end

  // Reset wins over load enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q  <= '0;
      state_q <= '0;
    end else begin
      word_q  <= word_d;
      state_q <= state_d;
    end
  end

  assign IRld   = word_q[IRLD_B];
  assign PCld   = word_q[PCLD_B];
  assign nPCld  = word_q[NPCLD_B];
  assign RFld   = word_q[RFLD_B];
  assign MA     = word_q[MA_B];
  assign MB     = word_q[MB_LSB +: 2];
  assign MC     = word_q[MC_B];
  assign ME     = word_q[ME_B];
  assign MF     = word_q[MF_B];
  assign MPA    = word_q[MPA_B];
  assign MP     = word_q[MP_B];
  assign MR     = word_q[MR_B];
  assign RW     = word_q[RW_B];
  assign MOV    = word_q[MOV_B];
  assign MDRld  = word_q[MDRLD_B];
  assign MARld  = word_q[MARLD_B];
  assign OpC    = word_q[OPC_LSB +: 6];
  assign Cin    = word_q[CIN_B];
  assign SSE    = word_q[SSE_LSB +: 2];
  assign OP     = word_q[OP_LSB +: 4];
  assign CR     = word_q[CR_LSB +: STATE_W];
  assign Inv    = word_q[INV_B];
  assign IncRld = word_q[INCRLD_B];
  assign S      = word_q[S_LSB +: 2];
  assign N      = word_q[N_LSB +: 3];

  assign active_state = state_q;
  assign inc_addr     = next_addr + STATE_W'(1);

  cond_select u_cond_select (
    .sel_i  (S),
    .moc_i  (moc),
    .cond_i (cond),
    .dmoc_i (dmoc),
    .inv_i  (Inv),
    .raw_o  (cond_raw),
    .sts_o  (sts)
  );
endmodule

// File: tb/tb_control_register.sv
// Directed bench for control_register: reset, field map, cond mux, adder, hold.
module tb_control_register;
  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [43:0] state_signals;
  logic [6:0]  cur_state, next_addr;
  logic        moc, cond, dmoc;
  logic        IRld, PCld, nPCld, RFld, MA, MC, ME, MF, MPA, MP, MR, RW, MOV, MDRld, MARld, Cin;
  logic [1:0]  MB, SSE, S;
  logic [5:0]  OpC;
  logic [3:0]  OP;
  logic [6:0]  CR, active_state, inc_addr;
  logic        Inv, IncRld, cond_raw, sts;
  logic [2:0]  N;
  logic [43:0] fields;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  control_register dut (
    .clk(clk), .reset(reset),
`ifdef CTRL_REG_LOAD_EN
    .ld_en(ld_en),
`endif
    .state_signals(state_signals), .cur_state(cur_state),
    .moc(moc), .cond(cond), .dmoc(dmoc), .next_addr(next_addr),
    .IRld(IRld), .PCld(PCld), .nPCld(nPCld), .RFld(RFld), .MA(MA), .MB(MB),
    .MC(MC), .ME(ME), .MF(MF), .MPA(MPA), .MP(MP), .MR(MR), .RW(RW), .MOV(MOV),
    .MDRld(MDRld), .MARld(MARld), .OpC(OpC), .Cin(Cin), .SSE(SSE), .OP(OP),
    .CR(CR), .Inv(Inv), .IncRld(IncRld), .S(S), .N(N),
    .active_state(active_state), .cond_raw(cond_raw), .sts(sts), .inc_addr(inc_addr)
  );

  // Reassemble outputs in microinstruction bit order.
  assign fields = {IRld, PCld, nPCld, RFld, MA, MB, MC, ME, MF, MPA, MP, MR, RW,
                   MOV, MDRld, MARld, OpC, Cin, SSE, OP, CR, Inv, IncRld, S, N};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [1:0] s, input logic inv);
    logic [43:0] w;
    w = '0;
    w[4:3] = s;
    w[6]   = inv;
    state_signals = w;
    step();
  endtask

  initial begin
    logic [43:0] one;
    reset = 1'b1; ld_en = 1'b1; state_signals = '1; cur_state = 7'h55;
    moc = 1'b0; cond = 1'b0; dmoc = 1'b0; next_addr = '0;

    step();
    chk("rst_fields", 64'(fields), 64'd0);
    chk("rst_state", 64'(active_state), 64'd0);
    chk("rst_sts", 64'(sts), 64'd0);

    reset = 1'b0;
    step();
    chk("ones_fields", 64'(fields), 64'hFFF_FFFF_FFFF);
    chk("ones_cr", 64'(CR), 64'd127);
    chk("ones_state", 64'(active_state), 64'h55);
    chk("ones_raw", 64'(cond_raw), 64'd0);
    chk("ones_sts", 64'(sts), 64'd1);

    for (int i = 43; i >= 0; i--) begin
      one = 44'd1;
      state_signals = one << i;
      cur_state = 7'(i);
      step();
      chk($sformatf("walk%0d", i), 64'(fields), 64'(one << i));
      chk($sformatf("walk_st%0d", i), 64'(active_state), 64'(i));
    end

    load_word(2'b00, 1'b0);
    moc = 1'b0; #1 chk("s00_moc0", 64'(cond_raw), 64'd0);
    moc = 1'b1; #1 chk("s00_moc1", 64'(cond_raw), 64'd1);
    chk("s00_sts", 64'(sts), 64'd1);
    moc = 1'b0; cond = 1'b1; dmoc = 1'b1; #1 chk("s00_only_moc", 64'(cond_raw), 64'd0);

    load_word(2'b01, 1'b0);
    cond = 1'b1; moc = 1'b0; dmoc = 1'b0; #1 chk("s01_c1", 64'(cond_raw), 64'd1);
    cond = 1'b0; moc = 1'b1; dmoc = 1'b1; #1 chk("s01_c0", 64'(cond_raw), 64'd0);

    load_word(2'b10, 1'b0);
    dmoc = 1'b1; moc = 1'b0; cond = 1'b0; #1 chk("s10_d1", 64'(cond_raw), 64'd1);
    dmoc = 1'b0; moc = 1'b1; cond = 1'b1; #1 chk("s10_d0", 64'(cond_raw), 64'd0);

    load_word(2'b11, 1'b0);
    for (int v = 0; v < 8; v++) begin
      {moc, cond, dmoc} = 3'(v);
      #1 chk($sformatf("s11_%0d", v), 64'(cond_raw), 64'd0);
    end

    load_word(2'b00, 1'b1);
    moc = 1'b0; #1 chk("inv_raw0", 64'(cond_raw), 64'd0);
    chk("inv_sts0", 64'(sts), 64'd1);
    moc = 1'b1; #1 chk("inv_raw1", 64'(cond_raw), 64'd1);
    chk("inv_sts1", 64'(sts), 64'd0);

    next_addr = 7'd0;   #1 chk("inc0", 64'(inc_addr), 64'd1);
    next_addr = 7'd1;   #1 chk("inc1", 64'(inc_addr), 64'd2);
    next_addr = 7'd10;  #1 chk("inc10", 64'(inc_addr), 64'd11);
    next_addr = 7'd126; #1 chk("inc126", 64'(inc_addr), 64'd127);
    next_addr = 7'd127; #1 chk("inc127", 64'(inc_addr), 64'd0);

    state_signals = 44'h123_4567_89AB; cur_state = 7'h2A;
    step();
    state_signals = 44'hEDC_BA98_7654; cur_state = 7'h11;
    #3 chk("hold_fields", 64'(fields), 64'h123_4567_89AB);
    chk("hold_state", 64'(active_state), 64'h2A);
    step();
    chk("new_fields", 64'(fields), 64'hEDC_BA98_7654);
    chk("new_state", 64'(active_state), 64'h11);

    reset = 1'b1;
    step();
    chk("midrst_fields", 64'(fields), 64'd0);
    chk("midrst_state", 64'(active_state), 64'd0);
    reset = 1'b0;
    step();
    chk("postrst_fields", 64'(fields), 64'hEDC_BA98_7654);

`ifdef CTRL_REG_LOAD_EN
    ld_en = 1'b0; state_signals = 44'h0F0_F0F0_F0F0; cur_state = 7'h7;
    step();
    chk("ld0_hold", 64'(fields), 64'hEDC_BA98_7654);
    chk("ld0_state", 64'(active_state), 64'h11);
    reset = 1'b1;
    step();
    chk("ld0_rst", 64'(fields), 64'd0);
    reset = 1'b0; ld_en = 1'b1;
    step();
    chk("ld1_load", 64'(fields), 64'h0F0_F0F0_F0F0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_register.md
Name: control_register

Overview:
- Microprogrammed control-unit pipeline register. Captures the 44-bit microinstruction and its state number from the microstore on each clock edge, and drives the decoded control fields to the datapath.
- Also contains two combinational sequencer helpers:
  - condition multiplexer: selects moc/cond/dmoc by the registered S field, then applies the Inv inversion;
  - incrementer adder: next-state address + 1, which feeds the external incrementer register.

Parameters:
- WORD_W, 44, microinstruction width; the field layout below is fixed for 44.
- STATE_W, 7, state/address width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- state_signals  input  WORD_W  microinstruction from microstore.
- cur_state  input  STATE_W  state number of that microinstruction.
- moc, cond, dmoc  input  1 each  memory-op-complete, datapath condition, data-memory-op-complete.
- next_addr  input  STATE_W  state-select mux output.
- IRld, PCld, nPCld, RFld, MA, MC, ME, MF, MPA, MP, MR, RW, MOV, MDRld, MARld, Cin  output  1 each  datapath loads and mux selects.
- MB  output  2  ALU B-operand mux select.
- OpC  output  6  ALU opcode.
- SSE  output  2  sign/shift extender mode.
- OP  output  4  memory operation code.
- CR  output  STATE_W  microinstruction jump target.
- Inv, IncRld  output  1 each  condition invert; incrementer register load.
- S  output  2  condition select.
- N  output  3  next-address-selector code.
- active_state  output  STATE_W  registered state number.
- cond_raw  output  1  condition mux output, before inversion.
- sts  output  1  cond_raw XOR Inv.
- inc_addr  output  STATE_W  next_addr + 1.

Behaviour:
- Field layout of state_signals, MSB first, fields contiguous:
  - IRld[43], PCld[42], nPCld[41], RFld[40], MA[39], MB[38:37], MC[36], ME[35], MF[34], MPA[33], MP[32], MR[31], RW[30], MOV[29], MDRld[28], MARld[27];
  - OpC[26:21], Cin[20], SSE[19:18], OP[17:14], CR[13:7], Inv[6], IncRld[5], S[4:3], N[2:0].
- Register update on every rising clk:
  - reset=1: 44-bit word register <= 0 and active_state <= 0, so every control output reads 0.
  - reset=0: word register <= state_signals and active_state <= cur_state.
- Latency: exactly one clock from the inputs to all field outputs and active_state. Between edges the outputs hold, whatever the inputs do.
- Reset is sampled only at the edge. Asserting it mid-operation clears the register at the next edge; the first edge after deassertion captures the current inputs.
- Condition mux (combinational, uses registered S): S=00 selects moc, 01 selects cond, 10 selects dmoc, 11 selects constant 0.
- sts = cond_raw ^ Inv (registered Inv), combinational.
- inc_addr = (next_addr + 1) mod 2^STATE_W, combinational. 127 wraps to 0; there is no carry output.
- No X propagation from unused bits; all outputs are defined at all times after the first reset edge.

Optional Feature:
- Macro CTRL_REG_LOAD_EN.
  - Defined: adds input ld_en (1 bit). At a non-reset edge the register and active_state load only when ld_en=1 and hold otherwise. Reset has priority over ld_en.
  - Undefined: no ld_en port; the register loads at every non-reset edge.

Decomposition:
- Shared package control_pkg holds:
  - WORD_W and STATE_W;
  - bit-position localparams for each field;
  - S encodings COND_MOC=2'b00, COND_COND=2'b01, COND_DMOC=2'b10, COND_ZERO=2'b11.
- One natural sub-module: cond_select (condition mux plus inverter). The register and the adder stay inline.

Test Plan:
- Reset: reset=1, state_signals=all ones, edge -> all outputs 0, active_state=0. Deassert reset, next edge -> all field outputs 1, CR=127, active_state=cur_state.
- Field mapping: apply a walking-one across bits 43..0 with cur_state=bit index -> exactly one output bit set, matching the layout above, one cycle later.
- Condition mux: S=00, moc 0→1 -> cond_raw follows moc. S=01 with cond=1 -> 1. S=10 with dmoc=1 -> 1. S=11 -> 0 for all inputs. Inv=1 -> sts is the complement of cond_raw.
- Adder: next_addr = 0, 1, 10, 126, 127 -> inc_addr = 1, 2, 11, 127, 0.
- Hold between edges: change state_signals between edges -> outputs unchanged until the next rising edge.
- With CTRL_REG_LOAD_EN defined: ld_en=0 with new word -> outputs hold. ld_en=0 and reset=1 -> cleared to 0.
